// File: rtl/bitstream_serializer_pkg.sv
// ============================================================================
// Module      : bitstream_serializer_pkg
// Description : Shared definitions for the bitstream serializer and the
//               detector benches: FSM state encoding (2-bit) and the default
//               word width.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bitstream_serializer_pkg;

    // Default word width, also reused by the detector benches
    localparam int BITSTREAM_WIDTH = 8;

    // FSM state encoding; ST_PARITY is only reached in parity builds
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/bitstream_serializer_hold_reg.sv
// ============================================================================
// Module      : bitstream_hold_reg
// Description : Single-entry holding register. WIDTH data flops plus a full
//               flag. A load wins over a take on the same edge, so a word
//               arriving while the previous one is handed off is kept.
// Ports       : iCLK  - clock
//               iRST  - asynchronous active-low reset
//               iLOAD - capture iDATA, set full
//               iTAKE - consumer took the word, clear full
//               iDATA - word to store
//               oDATA - stored word
//               oFULL - entry occupied
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitstream_hold_reg #(
    parameter int WIDTH = 8
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iLOAD,
    input  logic             iTAKE,
    input  logic [WIDTH-1:0] iDATA,
    output logic [WIDTH-1:0] oDATA,
    output logic             oFULL
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else begin
            if (iLOAD) begin
                r_data <= iDATA;
                r_full <= 1'b1;
            end else if (iTAKE) begin
                r_full <= 1'b0;
            end
        end
    end

    assign oDATA = r_data;
    assign oFULL = r_full;

endmodule

`default_nettype wire

// File: rtl/bitstream_serializer.sv
// ============================================================================
// Module      : bitstream_serializer
// Description : Parallel-to-serial converter. Accepts WIDTH-bit words over a
//               valid/ready handshake and emits them MSB-first, one bit per
//               clock. A one-word holding register keeps the stream gap-free
//               when the producer keeps up. oBIT is 0 while idle.
//               Optional build macro BITSTREAM_SER_PARITY_EN appends an even
//               parity bit after the LSB of every word.
// Ports       : iCLK       - clock, rising edge
//               iRST       - asynchronous active-low reset
//               iDATA      - parallel word, sampled on accept
//               iVALID     - producer has a word
//               oREADY     - block can take a word (holding register empty)
//               oBIT       - serial data, registered
//               oBIT_VALID - oBIT carries a frame bit, registered
//               oWORD_DONE - pulse during the final bit of a frame
//               oBUSY      - shifter or holding register occupied
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bitstream_serializer
    import bitstream_serializer_pkg::*;
#(
    parameter int WIDTH = BITSTREAM_WIDTH
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic [WIDTH-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    output logic             oBIT,
    output logic             oBIT_VALID,
    output logic             oWORD_DONE,
    output logic             oBUSY
);

    localparam int               CNT_W      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_LAST     = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_PRE_LAST = CNT_W'(WIDTH - 2);

    state_t           r_st;
    logic [WIDTH-1:0] r_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bit;
    logic             r_bitValid;
    logic             r_wordDone;
`ifdef BITSTREAM_SER_PARITY_EN
    logic             r_par;
`endif

    logic             w_holdFull;
    logic [WIDTH-1:0] w_holdData;
    logic             w_accept;
    logic             w_frameEnd;
    logic             w_loadSh;
    logic             w_loadHold;
    logic             w_take;
    logic [WIDTH-1:0] w_loadData;

    assign w_accept = iVALID && !w_holdFull;

    // Edge at which the last bit of the current frame ends
`ifdef BITSTREAM_SER_PARITY_EN
    assign w_frameEnd = (r_st == ST_PARITY);
`else
    assign w_frameEnd = (r_st == ST_SHIFT) && (r_cnt == c_LAST);
`endif

    // Shifter reloads from idle, or at frame end from hold (preferred) or
    // directly from the input so back-to-back frames have no gap.
    assign w_loadSh   = ((r_st == ST_IDLE) && w_accept) ||
                        (w_frameEnd && (w_holdFull || w_accept));
    assign w_loadData = w_holdFull ? w_holdData : iDATA;
    assign w_take     = w_frameEnd && w_holdFull;
    assign w_loadHold = w_accept && (r_st != ST_IDLE) && !w_frameEnd;

    bitstream_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iLOAD (w_loadHold),
        .iTAKE (w_take),
        .iDATA (iDATA),
        .oDATA (w_holdData),
        .oFULL (w_holdFull)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_st       <= ST_IDLE;
            r_sh       <= '0;
            r_cnt      <= '0;
            r_bit      <= 1'b0;
            r_bitValid <= 1'b0;
            r_wordDone <= 1'b0;
`ifdef BITSTREAM_SER_PARITY_EN
            r_par      <= 1'b0;
`endif
        end else if (w_loadSh) begin
            r_st       <= ST_SHIFT;
            r_sh       <= w_loadData;
            r_cnt      <= '0;
            r_bit      <= w_loadData[WIDTH-1];
            r_bitValid <= 1'b1;
            r_wordDone <= 1'b0;
`ifdef BITSTREAM_SER_PARITY_EN
            r_par      <= ^w_loadData;
`endif
        end else if (w_frameEnd) begin
            r_st       <= ST_IDLE;
            r_bit      <= 1'b0;
            r_bitValid <= 1'b0;
            r_wordDone <= 1'b0;
        end else if (r_st == ST_SHIFT) begin
`ifdef BITSTREAM_SER_PARITY_EN
            if (r_cnt == c_LAST) begin
                r_st       <= ST_PARITY;
                r_bit      <= r_par;
                r_wordDone <= 1'b1;
            end else begin
                r_sh       <= r_sh << 1;
                r_cnt      <= r_cnt + 1'b1;
                r_bit      <= r_sh[WIDTH-2];
                r_wordDone <= 1'b0;
            end
`else
            r_sh       <= r_sh << 1;
            r_cnt      <= r_cnt + 1'b1;
            r_bit      <= r_sh[WIDTH-2];
            // Next presented bit is the LSB, which closes the frame
            r_wordDone <= (r_cnt == c_PRE_LAST);
`endif
        end
    end

    assign oREADY     = !w_holdFull;
    assign oBIT       = r_bit;
    assign oBIT_VALID = r_bitValid;
    assign oWORD_DONE = r_wordDone;
    assign oBUSY      = (r_st != ST_IDLE) || w_holdFull;

endmodule

`default_nettype wire
